// File: rtl/sapho_fl_pkg.sv
// rtl/sapho_fl_pkg.sv - shared float-word format, converter states and saturation constants
package sapho_fl_pkg;

  // Default format of the processor float word {s, e, m}
  localparam int FL_EXP_W = 8;
  localparam int FL_MAN_W = 23;
  localparam int FL_NBITS = 32;

  // Field offsets; the ALU packer and the unpacker both derive positions from these
  function automatic int fl_man_lsb();
    return 0;
  endfunction

  function automatic int fl_exp_lsb(input int man_w);
    return man_w;
  endfunction

  function automatic int fl_sign_pos(input int man_w, input int exp_w);
    return man_w + exp_w;
  endfunction

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHL  = 2'd1,
    SHR  = 2'd2,
    FIN  = 2'd3
  } fl_state_t;

  // Largest positive two's-complement value of an nbits-wide integer
  function automatic logic [63:0] int_max(input int nbits);
    return (64'd1 << (nbits - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative nbits-wide integer (also its magnitude)
  function automatic logic [63:0] int_min(input int nbits);
    return 64'd1 << (nbits - 1);
  endfunction

endpackage

// File: rtl/fl_to_int.sv
// rtl/fl_to_int.sv - bit-serial float word to saturated two's-complement integer converter
module fl_to_int
  import sapho_fl_pkg::*;
#(
  parameter int EXP   = FL_EXP_W,
  parameter int MAN   = FL_MAN_W,
  parameter int NBITS = FL_NBITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAN+EXP:0]   in,
  output logic               busy,
  output logic               done,
  output logic [NBITS-1:0]   out,
  output logic               ovf
);

  localparam int SIGN_POS = fl_sign_pos(MAN, EXP);
  localparam int EXP_LSB  = fl_exp_lsb(MAN);
  localparam int MAN_LSB  = fl_man_lsb();

  localparam logic [63:0]      INT_MAX_W = int_max(NBITS);
  localparam logic [63:0]      INT_MIN_W = int_min(NBITS);
  localparam logic [NBITS-1:0] INT_MAX   = INT_MAX_W[NBITS-1:0];
  localparam logic [NBITS-1:0] INT_MIN   = INT_MIN_W[NBITS-1:0];
  localparam logic [EXP:0]     CNT_ONE   = {{EXP{1'b0}}, 1'b1};

  fl_state_t          state;
  logic               s;
  logic               sat;
  logic [NBITS-1:0]   mag;
  logic [EXP:0]       cnt;

  // Field split of the incoming word; only used in the accept cycle
  logic               in_s;
  logic [EXP-1:0]     in_e;
  logic [MAN-1:0]     in_m;
  logic [EXP:0]       e_ext;
  logic [EXP:0]       e_neg;
  logic [NBITS-1:0]   in_mag;

  assign in_s   = in[SIGN_POS];
  assign in_e   = in[EXP_LSB +: EXP];
  assign in_m   = in[MAN_LSB +: MAN];
  // One extra bit so that the negation of the most negative exponent still fits
  assign e_ext  = {in_e[EXP-1], in_e};
  assign e_neg  = -e_ext;
  assign in_mag = {{(NBITS-MAN){1'b0}}, in_m};

  logic [NBITS-1:0]   mag_shl;
  logic [NBITS-1:0]   mag_shr;
  logic [EXP:0]       cnt_dec;

  assign mag_shl = {mag[NBITS-2:0], 1'b0};
  assign mag_shr = {1'b0, mag[NBITS-1:1]};
  assign cnt_dec = cnt - CNT_ONE;

  assign busy = (state != IDLE);

  logic               fin_ovf;
  logic [NBITS-1:0]   fin_out;

  // Final sign application with saturation; -2^(NBITS-1) is exact for negative results
  always_comb begin
    fin_ovf = 1'b0;
    fin_out = mag;
    if (!s) begin
      if (sat || (mag > INT_MAX)) begin
        fin_ovf = 1'b1;
        fin_out = INT_MAX;
      end else begin
        fin_out = mag;
      end
    end else begin
      if (sat || (mag > INT_MIN)) begin
        fin_ovf = 1'b1;
        fin_out = INT_MIN;
      end else begin
        fin_out = -mag;
      end
    end
  end

  // Conversion FSM with the mag/cnt datapath and registered result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s     <= 1'b0;
      sat   <= 1'b0;
      mag   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      out   <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s   <= in_s;
            mag <= in_mag;
            sat <= 1'b0;
            // A zero mantissa is the canonical zero whatever its exponent
            if ((in_m == '0) || (e_ext == '0)) begin
              state <= FIN;
            end else if (e_ext[EXP]) begin
              cnt   <= e_neg;
              state <= SHR;
            end else begin
              cnt   <= e_ext;
              state <= SHL;
            end
          end
        end
        SHL: begin
          // A set MSB means another shift would overflow, so stop here
          if (mag[NBITS-1]) begin
            sat   <= 1'b1;
            state <= FIN;
          end else begin
            mag <= mag_shl;
            cnt <= cnt_dec;
            if (cnt_dec == '0) begin
              state <= FIN;
            end
          end
        end
        SHR: begin
          mag <= mag_shr;
          cnt <= cnt_dec;
          // Once everything has been shifted out the result cannot change
          if ((cnt_dec == '0) || (mag_shr == '0)) begin
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          out   <= fin_out;
          ovf   <= fin_ovf;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
